// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: commit-time TLBRD/TLBWR/TLBFILL/INVTLB sequencer.
// Ports: req_* from WB, r_* TLB read port, tlb_we/inv_we/tlbrd_we strobes, done/err/refetch.
module tlb_op_sequencer #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_asid,
  input  logic [18:0]     req_vppn,
  input  logic [IDXW-1:0] csr_tlbidx_index,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic            r_g,
  input  logic [9:0]      r_asid,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  output logic            tlb_we,
  output logic [IDXW-1:0] w_index,
  output logic            inv_we,
  output logic [IDXW-1:0] inv_index,
  output logic            tlbrd_we,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            refetch
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SCAN
  } state_e;

  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [3:0]      lfsr_q, lfsr_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      inv_q, inv_d;
  logic [9:0]      asid_q, asid_d;
  logic [18:0]     vppn_q, vppn_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [3:0]      fidx_q, fidx_d;

  logic accept;
  logic asid_eq;
  logic va_eq;
  logic match;
  logic is_rd, is_wr, is_fill, is_inv;

  // Reset gates ready so every output reads 0 while resetn is low.
  assign req_ready = (state_q == IDLE) && resetn;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE);

  // Fibonacci LFSR; never reaches 0, so TLBFILL never hits entry 0.
  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  assign is_rd   = (op_q == OP_RD);
  assign is_wr   = (op_q == OP_WR);
  assign is_fill = (op_q == OP_FILL);
  assign is_inv  = (op_q == OP_INV);

  always_comb begin
    op_d   = op_q;
    inv_d  = inv_q;
    asid_d = asid_q;
    vppn_d = vppn_q;
    idx_d  = idx_q;
    fidx_d = fidx_q;
    if (accept) begin
      op_d   = req_op;
      inv_d  = req_inv_op;
      asid_d = req_asid;
      vppn_d = req_vppn;
      idx_d  = csr_tlbidx_index;
      fidx_d = lfsr_q;
    end
  end

  // 2MB pages compare only the upper VPPN bits.
  assign asid_eq = (r_asid == asid_q);
  assign va_eq   = (r_ps == 6'd21)
                 ? (r_vppn[18:9] == vppn_q[18:9])
                 : (r_vppn == vppn_q);

  always_comb begin
    match = 1'b0;
    unique case (inv_q)
      5'd0, 5'd1: match = 1'b1;
      5'd2:       match = r_g;
      5'd3:       match = !r_g;
      5'd4:       match = !r_g && asid_eq;
      5'd5:       match = !r_g && asid_eq && va_eq;
      5'd6:       match = (r_g || asid_eq) && va_eq;
      default:    match = 1'b0;
    endcase
    match = match && r_e;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_index   = '0;
    tlb_we    = 1'b0;
    w_index   = '0;
    inv_we    = 1'b0;
    inv_index = '0;
    tlbrd_we  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    refetch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (req_op == OP_INV && req_inv_op <= 5'd6)
                  ? SCAN : EXEC;
        end
      end
      EXEC: begin
        done    = 1'b1;
        refetch = 1'b1;
        state_d = IDLE;
        unique case (1'b1)
          is_rd: begin
            r_index  = idx_q;
            tlbrd_we = 1'b1;
          end
          is_wr: begin
            tlb_we  = 1'b1;
            w_index = idx_q;
          end
          is_fill: begin
            tlb_we  = 1'b1;
            w_index = IDXW'(fidx_q);
          end
          is_inv: begin
            err     = 1'b1;
            refetch = 1'b0;
          end
          default: ;
        endcase
      end
      SCAN: begin
        r_index   = cnt_q;
        inv_index = cnt_q;
        inv_we    = match;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          done    = 1'b1;
          refetch = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= 4'b0001;
      op_q    <= '0;
      inv_q   <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      idx_q   <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
      asid_q  <= asid_d;
      vppn_q  <= vppn_d;
      idx_q   <= idx_d;
      fidx_q  <= fidx_d;
    end
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// tb_tlb_op_sequencer: random + directed bench for tlb_op_sequencer.
// Holds a behavioural 16-entry TLB and an op-level reference model.
module tb_tlb_op_sequencer;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  inv;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [3:0]  idx;
  } op_t;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_asid;
  logic [18:0] req_vppn;
  logic [3:0]  csr_tlbidx_index;
  logic [3:0]  r_index;
  logic        r_e;
  logic        r_g;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic        tlb_we;
  logic [3:0]  w_index;
  logic        inv_we;
  logic [3:0]  inv_index;
  logic        tlbrd_we;
  logic        busy;
  logic        done;
  logic        err;
  logic        refetch;

  logic        tlb_e    [16];
  logic        tlb_g    [16];
  logic [9:0]  tlb_asid [16];
  logic [18:0] tlb_vppn [16];
  logic [5:0]  tlb_ps   [16];

  int          total = 0;
  int          bad   = 0;
  int          cyc;
  logic [15:0] seen_clr;
  logic [3:0]  last_w;

  tlb_op_sequencer #(.TLBNUM(16), .IDXW(4)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_inv_op       (req_inv_op),
    .req_asid         (req_asid),
    .req_vppn         (req_vppn),
    .csr_tlbidx_index (csr_tlbidx_index),
    .r_index          (r_index),
    .r_e              (r_e),
    .r_g              (r_g),
    .r_asid           (r_asid),
    .r_vppn           (r_vppn),
    .r_ps             (r_ps),
    .tlb_we           (tlb_we),
    .w_index          (w_index),
    .inv_we           (inv_we),
    .inv_index        (inv_index),
    .tlbrd_we         (tlbrd_we),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .refetch          (refetch)
  );

  assign r_e    = tlb_e[r_index];
  assign r_g    = tlb_g[r_index];
  assign r_asid = tlb_asid[r_index];
  assign r_vppn = tlb_vppn[r_index];
  assign r_ps   = tlb_ps[r_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; indexes the LFSR sequence.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lfsr_at(input int k);
    logic [3:0] v;
    v = 4'b0001;
    for (int s = 0; s < k % 15; s++)
      v = {v[2:0], v[3] ^ v[2]};
    return v;
  endfunction

  function automatic logic [18:0] pick_vppn();
    logic [18:0] pool [3];
    pool[0] = 19'h1234A;
    pool[1] = 19'h12200;
    pool[2] = 19'h55555;
    return pool[$urandom_range(0, 2)];
  endfunction

  function automatic logic [9:0] pick_asid();
    return ($urandom_range(0, 1) == 0) ? 10'h012 : 10'h034;
  endfunction

  function automatic bit m_match(input int i, input op_t c);
    bit g, ae, va;
    g  = tlb_g[i];
    ae = (tlb_asid[i] == c.asid);
    if (tlb_ps[i] == 6'd12) va = (tlb_vppn[i] == c.vppn);
    else va = (tlb_vppn[i][18:9] == c.vppn[18:9]);
    if (!tlb_e[i]) return 1'b0;
    case (c.inv)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && ae;
      5'd5:       return !g && ae && va;
      5'd6:       return (g || ae) && va;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic rand_entry(input int i);
    tlb_e[i]    = ($urandom_range(0, 3) != 0);
    tlb_g[i]    = 1'($urandom_range(0, 1));
    tlb_asid[i] = pick_asid();
    tlb_vppn[i] = pick_vppn();
    tlb_ps[i]   = ($urandom_range(0, 1) == 0) ? 6'd12 : 6'd21;
  endtask

  task automatic rand_tlb();
    for (int i = 0; i < 16; i++) rand_entry(i);
  endtask

  function automatic op_t rand_op();
    op_t c;
    c.op   = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 2) == 0) c.op = 3'd4;
    c.inv  = ($urandom_range(0, 7) == 0)
           ? 5'($urandom_range(0, 31))
           : 5'($urandom_range(0, 8));
    c.asid = pick_asid();
    c.vppn = pick_vppn();
    c.idx  = 4'($urandom_range(0, 15));
    return c;
  endfunction

  task automatic drive(input op_t c);
    req_op           = c.op;
    req_inv_op       = c.inv;
    req_asid         = c.asid;
    req_vppn         = c.vppn;
    csr_tlbidx_index = c.idx;
  endtask

  // One clock; the bench TLB applies the strobes seen in that cycle.
  task automatic tick();
    logic       iw, tw;
    logic [3:0] ii, wi;
    iw = inv_we;
    tw = tlb_we;
    ii = inv_index;
    wi = w_index;
    @(posedge clk);
    if (iw) tlb_e[ii] = 1'b0;
    if (tw) rand_entry(int'(wi));
    #1;
  endtask

  // Issue c from idle; optionally hold n during the op. stop_at>=0 ends a
  // walk early (just before cycle stop_at is checked).
  task automatic do_op(input op_t c, input bit b2b,
                       input op_t n, input int stop_at);
    logic [3:0]  elfsr;
    logic [15:0] eclr;
    bit          scan, e_err, e_tw, e_rd;
    req_valid = 1'b1;
    drive(c);
    chk("ready", req_ready, 1);
    chk("busy_idle", busy, 0);
    elfsr = lfsr_at(cyc);
    for (int i = 0; i < 16; i++) eclr[i] = m_match(i, c);
    scan = (c.op == 3'd4) && (c.inv <= 5'd6);
    tick();
    if (b2b) drive(n);
    else begin
      req_valid = 1'b0;
      drive(rand_op());
    end
    seen_clr = '0;
    if (scan) begin
      for (int k = 0; k < 16; k++) begin
        if (k == stop_at) return;
        chk("scan_ridx", r_index, k);
        chk("scan_iidx", inv_index, k);
        chk("scan_inv_we", inv_we, eclr[k]);
        chk("scan_misc",
            {tlb_we, tlbrd_we, err, busy, req_ready}, 5'b00010);
        chk("scan_done", {done, refetch},
            (k == 15) ? 2'b11 : 2'b00);
        if (inv_we) seen_clr[k] = 1'b1;
        tick();
      end
    end else begin
      e_err = (c.op == 3'd4);
      e_tw  = (c.op == 3'd2) || (c.op == 3'd3);
      e_rd  = (c.op == 3'd1);
      chk("x_flags", {done, busy, req_ready, err, refetch},
          {3'b110, e_err, !e_err});
      chk("x_strobes", {tlb_we, tlbrd_we, inv_we},
          {e_tw, e_rd, 1'b0});
      if (e_rd) chk("x_ridx", r_index, c.idx);
      if (c.op == 3'd2) chk("x_widx_wr", w_index, c.idx);
      if (c.op == 3'd3) begin
        chk("x_widx_fill", w_index, elfsr);
        chk("x_fill_nz", w_index != 4'd0, 1);
      end
      last_w = w_index;
      tick();
    end
    chk("idle_after",
        {req_ready, busy, done, tlb_we, tlbrd_we, inv_we},
        6'b100000);
  endtask

  function automatic logic [19:0] outs();
    return {req_ready, r_index, tlb_we, w_index, inv_we,
            inv_index, tlbrd_we, busy, done, err, refetch};
  endfunction

  initial begin
    op_t c, n;
    bit  b2b;
    resetn    = 1'b0;
    req_valid = 1'b0;
    c = '{op: 3'd0, inv: 5'd0, asid: 10'd0, vppn: 19'd0, idx: 4'd0};
    drive(c);
    rand_tlb();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    resetn = 1'b1;

    // Three TLBFILLs accepted at edges 3, 6 and 9 after reset.
    c.op = 3'd3;
    repeat (3) tick();
    do_op(c, 0, c, -1);
    chk("fill1_w", last_w, 4'b1001);
    tick();
    do_op(c, 0, c, -1);
    chk("fill2_w", last_w, 4'b1101);
    tick();
    do_op(c, 0, c, -1);
    chk("fill3_w", last_w, 4'b1011);

    c = '{op: 3'd2, inv: 5'd0, asid: 10'd0, vppn: 19'd0, idx: 4'd5};
    do_op(c, 0, c, -1);
    c.op  = 3'd1;
    c.idx = 4'd9;
    do_op(c, 0, c, -1);

    // INVTLB 5: only entries 3 and 10 qualify.
    for (int i = 0; i < 16; i++) tlb_e[i] = 1'b0;
    tlb_e[3] = 1'b1;  tlb_g[3] = 1'b0;  tlb_asid[3] = 10'h012;
    tlb_ps[3] = 6'd12; tlb_vppn[3] = 19'h1234A;
    tlb_e[7] = 1'b1;  tlb_g[7] = 1'b1;  tlb_asid[7] = 10'h012;
    tlb_ps[7] = 6'd12; tlb_vppn[7] = 19'h1234A;
    tlb_e[10] = 1'b1; tlb_g[10] = 1'b0; tlb_asid[10] = 10'h012;
    tlb_ps[10] = 6'd21; tlb_vppn[10] = 19'h12200;
    c = '{op: 3'd4, inv: 5'd5, asid: 10'h012,
          vppn: 19'h1234A, idx: 4'd0};
    do_op(c, 0, c, -1);
    chk("inv5_set", seen_clr, 16'h0408);

    c.inv = 5'd7;
    do_op(c, 0, c, -1);

    rand_tlb();
    n = rand_op();
    for (int i = 0; i < 150; i++) begin
      c   = n;
      n   = rand_op();
      b2b = 1'($urandom_range(0, 1));
      do_op(c, b2b, n, -1);
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 3) == 0) rand_tlb();
      end
    end

    // Reset during a walk with a TLBWR held behind it.
    rand_tlb();
    c = '{op: 3'd4, inv: 5'd0, asid: 10'h0, vppn: 19'h0, idx: 4'd0};
    n = '{op: 3'd2, inv: 5'd0, asid: 10'h0, vppn: 19'h0, idx: 4'd5};
    do_op(c, 1, n, 7);
    resetn = 1'b0;
    #1;
    chk("midscan_rst", outs(), 0);
    @(posedge clk);
    #1;
    chk("rst_held", outs(), 0);
    resetn = 1'b1;
    #1;
    do_op(n, 0, n, -1);
    chk("post_rst_w", last_w, 4'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
